bg_parallax_starfield: RTL and testbench

//  Procedural space background: NUM_LAYERS hashed starfield layers scrolling at different speeds (parallax),
//  per-star twinkle and an LFSR-launched shooting star. Stars need no coordinate ROM. Sits in the bg mux

---
 rtl/bg_parallax_starfield.sv | 220 ++++++++++++++++++++++
 tb/tb_bg_parallax_starfield.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_parallax_starfield.sv
// bg_parallax_starfield
//   Procedural space background. NUM_LAYERS hashed starfield layers scroll
//   horizontally at different speeds (parallax). Each star twinkles off for
//   one frame in eight. An LFSR-launched shooting star with a diagonal trail
//   is drawn on top. Stars are derived from a hash of their 16x16 cell
//   coordinates, so no coordinate ROM is needed. vsync is only edge-detected;
//   all state runs on clk.
//
// Ports
//   clk           pixel clock
//   rst_n         asynchronous active-low reset
//   bg_en         1 = generate and animate, 0 = freeze state and output black
//   video_active  1 = current pixel is visible
//   pix_x, pix_y  current pixel coordinates (COORD_W bits)
//   vsync         frame sync, active level given by VSYNC_POL
//   meteor_trig   one-clock pulse that forces a shooting-star launch
//   R, G, B       registered 2-bit colour, one clock after the pixel inputs
module bg_parallax_starfield #(
  parameter int H_RES      = 1024,
  parameter int V_RES      = 768,
  parameter int COORD_W    = 11,
  parameter int NUM_LAYERS = 3,
  parameter int BASE_SPEED = 1,
  parameter int DENSITY    = 2,
  parameter int METEOR_SPD = 8,
  parameter int TRAIL_LEN  = 24,
  parameter int VSYNC_POL  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bg_en,
  input  logic               video_active,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               vsync,
  input  logic               meteor_trig,
  output logic [1:0]         R,
  output logic [1:0]         G,
  output logic [1:0]         B
);

  localparam int         SUM_W   = COORD_W + 1;
  localparam logic       VS_ACT  = (VSYNC_POL != 0);
  localparam logic [5:0] C_WHITE = 6'b11_11_11;
  localparam logic [5:0] C_DIM   = 6'b01_01_10;
  localparam logic [5:0] C_TRAIL = 6'b11_11_00;

  typedef enum logic {S_IDLE, S_ACTIVE} meteor_state_t;

  // ---------------------------------------------------------------------------
  // Frame tick: first clock on which vsync is seen at its active level.
  // ---------------------------------------------------------------------------
  logic r_vs_q;
  logic w_tick;
  logic w_adv;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vs_q <= ~VS_ACT;
    else        r_vs_q <= vsync;
  end

  // vs_q keeps tracking while bg_en=0 so re-enabling cannot fake an edge.
  assign w_tick = (vsync == VS_ACT) && (r_vs_q != VS_ACT);
  assign w_adv  = w_tick && bg_en;

  // ---------------------------------------------------------------------------
  // Per-frame animation state: layer scroll offsets, twinkle phase, LFSR.
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] r_scroll [NUM_LAYERS];
  logic [COORD_W-1:0] w_scroll_nxt [NUM_LAYERS];
  logic [SUM_W-1:0]   w_scr_sum;
  logic [2:0]         r_twinkle;
  logic [15:0]        r_lfsr;
  logic [15:0]        w_lfsr_nxt;

  // NOTE: every signal assigned in a combinational block gets a default at
  // the top, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_scr_sum = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      w_scr_sum = {1'b0, r_scroll[k]} + SUM_W'(BASE_SPEED * (k + 1));
      if (w_scr_sum >= SUM_W'(H_RES)) w_scr_sum = w_scr_sum - SUM_W'(H_RES);
      w_scroll_nxt[k] = w_scr_sum[COORD_W-1:0];
    end
  end

  // Galois LFSR, right-shifting, feedback mask 0xB400.
  assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);

  // NOTE: the scroll array is only NUM_LAYERS flops, so it is reset like any
  // other register; a large RAM-backed array would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_LAYERS; k++) r_scroll[k] <= '0;
      r_twinkle <= '0;
      r_lfsr    <= 16'hACE1;
    end else if (w_adv) begin
      for (int k = 0; k < NUM_LAYERS; k++) r_scroll[k] <= w_scroll_nxt[k];
      r_twinkle <= r_twinkle + 3'd1;
      r_lfsr    <= w_lfsr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Shooting-star FSM. The head enters at the right edge and moves down-left
  // once per frame. A manual trigger launches even while frozen.
  // ---------------------------------------------------------------------------
  meteor_state_t      r_state, w_state_nxt;
  logic [COORD_W-1:0] r_head_x, r_head_y;
  logic [COORD_W-1:0] w_head_x_nxt, w_head_y_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_head_x <= '0;
      r_head_y <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_head_x <= w_head_x_nxt;
      r_head_y <= w_head_y_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_head_x_nxt = r_head_x;
    w_head_y_nxt = r_head_y;
    case (r_state)
      S_IDLE: begin
        // A launch takes priority over movement; the new head does not move
        // on its launch clock even if a frame tick arrives at the same time.
        if (meteor_trig || (w_adv && (r_lfsr[7:0] == 8'd0))) begin
          w_state_nxt  = S_ACTIVE;
          w_head_x_nxt = COORD_W'(H_RES - 1);
          w_head_y_nxt = COORD_W'(r_lfsr[15:8]);
        end
      end
      S_ACTIVE: begin
        if (w_adv) begin
          // Retire before a step would leave the screen (and underflow head_x).
          if ((r_head_x < COORD_W'(METEOR_SPD)) ||
              (({1'b0, r_head_y} + SUM_W'(METEOR_SPD / 2)) >= SUM_W'(V_RES))) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_head_x_nxt = r_head_x - COORD_W'(METEOR_SPD);
            w_head_y_nxt = r_head_y + COORD_W'(METEOR_SPD / 2);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pixel colour.
  // ---------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0] w_layer_hit;
  logic [SUM_W-1:0]      w_px_sum;
  logic [COORD_W-1:0]    w_sx, w_cx, w_cy;
  logic [7:0]            w_h;
  logic                  w_in_range;
  logic                  w_head_hit, w_trail_hit;
  logic [SUM_W-1:0]      w_d;
  logic [5:0]            w_rgb;

  always_comb begin
    w_layer_hit = '0;
    w_px_sum    = '0;
    w_sx        = '0;
    w_cx        = '0;
    w_h         = '0;
    w_cy        = pix_y >> 4;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      w_px_sum = {1'b0, pix_x} + {1'b0, r_scroll[k]};
      if (w_px_sum >= SUM_W'(H_RES)) w_px_sum = w_px_sum - SUM_W'(H_RES);
      w_sx = w_px_sum[COORD_W-1:0];
      w_cx = w_sx >> 4;
      // Cell hash: only the low byte of each product matters.
      w_h  = 8'(w_cx * 8'd37) ^ 8'(w_cy * 8'd101) ^ 8'(k * 59);
      // Star sits at (h[3:0], {h[1:0],h[3:2]}) inside its 16x16 cell.
      w_layer_hit[k] = ({1'b0, w_h[7:4]} < 5'(DENSITY)) &&
                       (w_sx[3:0] == w_h[3:0]) &&
                       (pix_y[3:0] == {w_h[1:0], w_h[3:2]}) &&
                       ((w_cx[2:0] ^ w_cy[2:0]) != r_twinkle);
    end
  end

  assign w_in_range = ({1'b0, pix_x} < SUM_W'(H_RES));
  assign w_head_hit = (r_state == S_ACTIVE) && (pix_x == r_head_x) && (pix_y == r_head_y);

  // Trail runs to the upper right of the head, rising 1 px per 2 px of x.
  // The y test is written as an addition so it cannot underflow.
  assign w_d         = {1'b0, pix_x} - {1'b0, r_head_x};
  assign w_trail_hit = (r_state == S_ACTIVE) && (pix_x > r_head_x) &&
                       (w_d < SUM_W'(TRAIL_LEN)) &&
                       (({1'b0, pix_y} + (w_d >> 1)) == {1'b0, r_head_y});

  always_comb begin
    w_rgb = '0;
    // Ascending scan so the nearest (highest-index) layer wins.
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (w_layer_hit[k]) w_rgb = (k == NUM_LAYERS - 1) ? C_WHITE : C_DIM;
    end
    if (w_trail_hit) w_rgb = C_TRAIL;
    if (w_head_hit)  w_rgb = C_WHITE;
  end

  logic [5:0] r_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_rgb <= '0;
    else if (!bg_en || !video_active || !w_in_range) r_rgb <= '0;
    else                                           r_rgb <= w_rgb;
  end

  assign {R, G, B} = r_rgb;

endmodule

// File: tb/tb_bg_parallax_starfield.sv
// Self-checking bench for bg_parallax_starfield. A behavioural model of the
// animation state and pixel colour produces expected values; expectations are
// queued when a pixel is driven and compared when the registered colour is due.
module tb_bg_parallax_starfield;

  localparam int H_RES = 1024;
  localparam int V_RES = 768;
  localparam int CW    = 11;
  localparam int NL    = 3;

  localparam logic [5:0] WHITE = 6'b11_11_11;
  localparam logic [5:0] DIM   = 6'b01_01_10;
  localparam logic [5:0] TRAIL = 6'b11_11_00;

  logic          clk = 1'b0;
  logic          rst_n, bg_en, video_active, vsync, meteor_trig;
  logic [CW-1:0] pix_x, pix_y;
  logic [1:0]    R, G, B;

  bg_parallax_starfield dut (
    .clk(clk), .rst_n(rst_n), .bg_en(bg_en), .video_active(video_active),
    .pix_x(pix_x), .pix_y(pix_y), .vsync(vsync), .meteor_trig(meteor_trig),
    .R(R), .G(G), .B(B)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: RGB got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [5:0] exp;
    int         due;
    string      name;
  } sb_t;
  sb_t sb_q[$];

  always @(negedge clk) begin
    sb_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check(e.name, {R, G, B}, e.exp);
    end
  end

  // ---------------- reference model ----------------
  int m_scroll[NL];
  int m_twinkle, m_lfsr, m_hx, m_hy;
  bit m_active, m_en;

  task automatic model_reset();
    for (int k = 0; k < NL; k++) m_scroll[k] = 0;
    m_twinkle = 0;
    m_lfsr    = 'hACE1;
    m_active  = 0;
    m_hx      = 0;
    m_hy      = 0;
  endtask

  // State change at one clock edge given whether it carries a tick / trigger.
  task automatic model_edge(input bit tick, input bit trig);
    bit adv;
    adv = tick && m_en;
    if (!m_active && (trig || (adv && (m_lfsr % 256) == 0))) begin
      m_active = 1;
      m_hx     = H_RES - 1;
      m_hy     = m_lfsr / 256;
    end else if (m_active && adv) begin
      if (m_hx < 8 || m_hy + 4 >= V_RES) m_active = 0;
      else begin
        m_hx = m_hx - 8;
        m_hy = m_hy + 4;
      end
    end
    if (adv) begin
      for (int k = 0; k < NL; k++) m_scroll[k] = (m_scroll[k] + (k + 1)) % H_RES;
      m_twinkle = (m_twinkle + 1) % 8;
      m_lfsr    = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
    end
  endtask

  function automatic logic [5:0] model_px(input int x, input int y, input bit va);
    int sx, cx, cy, h, d;
    if (!m_en || !va || x >= H_RES) return 6'd0;
    if (m_active && x == m_hx && y == m_hy) return WHITE;
    if (m_active) begin
      d = x - m_hx;
      if (d > 0 && d < 24 && y == m_hy - d / 2) return TRAIL;
    end
    for (int k = NL - 1; k >= 0; k--) begin
      sx = (x + m_scroll[k]) % H_RES;
      cx = sx / 16;
      cy = y / 16;
      h  = ((cx * 37) ^ (cy * 101) ^ (k * 59)) & 255;
      if (h / 16 < 2 && sx % 16 == h % 16 && y % 16 == (h % 4) * 4 + (h / 4) % 4 &&
          ((cx % 8) ^ (cy % 8)) != m_twinkle)
        return (k == NL - 1) ? WHITE : DIM;
    end
    return 6'd0;
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic send(input int x, input int y, input bit va, input logic [5:0] exp,
                      input string name);
    sb_t e;
    @(posedge clk); #1;
    pix_x        = CW'(x);
    pix_y        = CW'(y);
    video_active = va;
    e.exp  = exp;
    e.due  = cyc + 1;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic send_m(input int x, input int y, input bit va, input string name);
    send(x, y, va, model_px(x, y, va), name);
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results pending, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_tick(input bit trig);
    @(posedge clk); #1;
    vsync       = 1'b1;
    meteor_trig = trig;
    model_edge(1'b1, trig);
    @(posedge clk); #1;
    vsync       = 1'b0;
    meteor_trig = 1'b0;
    @(posedge clk);
  endtask

  task automatic do_trig();
    @(posedge clk); #1;
    meteor_trig = 1'b1;
    model_edge(1'b0, 1'b1);
    @(posedge clk); #1;
    meteor_trig = 1'b0;
  endtask

  task automatic set_en(input bit v);
    @(posedge clk); #1;
    bg_en = v;
    m_en  = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    video_active = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic scan_row(input int y, input string name);
    for (int x = 0; x < H_RES; x++) send_m(x, y, 1'b1, name);
    drain();
  endtask

  // ---------------- vector table (reset state) ----------------
  typedef struct {
    int         x;
    int         y;
    bit         va;
    logic [5:0] exp;
    string      name;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hy_saved;

    tbl[0] = '{115,   12, 1'b1, DIM,   "l0_star"};
    tbl[1] = '{116,   12, 1'b1, 6'd0,  "l0_neighbour"};
    tbl[2] = '{57,     6, 1'b1, WHITE, "l2_star"};
    tbl[3] = '{30,    11, 1'b1, DIM,   "l1_star"};
    tbl[4] = '{0,      0, 1'b1, 6'd0,  "twinkle0_blank"};
    tbl[5] = '{1139,  12, 1'b1, 6'd0,  "x_out_of_range"};
    tbl[6] = '{115,   12, 1'b0, 6'd0,  "va0_l0_star"};
    tbl[7] = '{57,     6, 1'b0, 6'd0,  "va0_l2_star"};

    rst_n = 1'b0; bg_en = 1'b1; video_active = 1'b0; vsync = 1'b0;
    meteor_trig = 1'b0; pix_x = '0; pix_y = '0;
    m_en = 1'b1;
    model_reset();
    #1;
    check("reset_rgb", {R, G, B}, 6'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) send(tbl[i].x, tbl[i].y, tbl[i].va, tbl[i].exp, tbl[i].name);
    drain();

    // ---- shooting star ----
    do_trig();
    send(1023, 172, 1'b1, WHITE, "head_launch");
    send(1023, 172, 1'b0, 6'd0,  "head_va0");
    drain();
    do_tick(1'b0);
    send(1015, 176, 1'b1, WHITE, "head_move1");
    send(1016, 176, 1'b1, TRAIL, "trail_d1");
    send(1020, 174, 1'b1, TRAIL, "trail_d5");
    send(1023, 172, 1'b1, TRAIL, "old_head_trail");
    drain();
    do_trig();
    send(1015, 176, 1'b1, WHITE, "trig_ignored");
    drain();
    repeat (100) do_tick(1'b0);
    send(215, 576, 1'b1, WHITE, "head_move101");
    send(238, 565, 1'b1, TRAIL, "trail_d23");
    send_m(239, 564, 1'b1, "trail_d24_end");
    send_m(214, 576, 1'b1, "left_of_head");
    drain();
    repeat (26) do_tick(1'b0);
    send(7, 680, 1'b1, WHITE, "head_move127");
    drain();
    do_tick(1'b0);
    send_m(7, 680, 1'b1, "retired_128");
    drain();
    do_tick(1'b1);
    send(1023, m_hy, 1'b1, WHITE, "relaunch_trig_tick");
    send_m(1015, m_hy + 4, 1'b1, "relaunch_no_move");
    drain();

    // ---- asynchronous reset mid-line, head pixel on screen ----
    hy_saved = m_hy;
    send(1023, hy_saved, 1'b1, WHITE, "head_before_rst");
    drain();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", {R, G, B}, 6'd0);
    video_active = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(115, 12, 1'b1, DIM, "post_rst_scroll0");
    send_m(1023, hy_saved, 1'b1, "post_rst_idle");
    drain();
    do_trig();
    send(1023, 172, 1'b1, WHITE, "post_rst_lfsr");
    drain();

    // ---- scrolling, twinkle, freeze ----
    do_reset();
    repeat (3) do_tick(1'b0);
    send(112, 12, 1'b1, DIM,  "scroll3_l0");
    send(24,  11, 1'b1, DIM,  "scroll6_l1");
    send(48,   6, 1'b1, 6'd0, "scroll9_l2_twinkle");
    drain();
    repeat (2) do_tick(1'b0);
    send(110, 12, 1'b1, DIM, "l0_after5");
    send_m(115, 12, 1'b1, "l0_old_pos");
    drain();
    repeat (2) do_tick(1'b0);
    send(108, 12, 1'b1, 6'd0, "l0_twinkle7_blank");
    drain();
    set_en(1'b0);
    repeat (4) do_tick(1'b0);
    send(16, 11, 1'b1, 6'd0, "en0_black");
    send_m(108, 12, 1'b1, "en0_black_model");
    drain();
    set_en(1'b1);
    send(16,  11, 1'b1, DIM,  "held_scroll_l1");
    send(108, 12, 1'b1, 6'd0, "held_twinkle7");
    drain();
    do_tick(1'b0);
    send(107, 12, 1'b1, DIM, "resume_l0");
    drain();
    scan_row(12, "row12");

    // ---- scroll wrap: 682 ticks puts layer 2 at 1022 ----
    repeat (674) do_tick(1'b0);
    send(59, 6, 1'b1, WHITE, "l2_scroll1022");
    drain();
    do_tick(1'b0);
    send(163, 1, 1'b1, WHITE, "l2_scroll_wrap1");
    drain();
    scan_row(6, "row6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
